// File: rtl/correlator_sweep_pkg.sv
// Shared defaults and FSM state encoding for the XOR offset-sweep correlator.
package correlator_sweep_pkg;

   localparam int DEF_LINE_W  = 128;
   localparam int DEF_WIN_W   = 96;
   localparam int DEF_WIN_H   = 64;
   localparam int DEF_Y_RANGE = 32;
   localparam int DEF_ADDR_W  = 10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_P = 3'd1,
      S_RD_C = 3'd2,
      S_LD_C = 3'd3,
      S_POP  = 3'd4,
      S_ACC  = 3'd5,
      S_CMP  = 3'd6,
      S_DONE = 3'd7
   } corr_state_e;

endpackage

// File: rtl/correlator_sweep_popcount_reg.sv
// Registered population count of an N-bit vector, one cycle of latency.
module popcount_reg #(
   parameter  int N  = 96,
   localparam int PW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [N-1:0]  i_data,
   output logic [PW-1:0] o_count
);

   logic [PW-1:0] w_count;
   logic [PW-1:0] r_count;

   // Adder chain over all input bits.
   always_comb begin
      w_count = '0;
      for (int i = 0; i < N; i++) begin
         w_count = w_count + PW'(i_data[i]);
      end
   end

   // Output register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else begin
         r_count <= w_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/correlator_sweep.sv
// Sweeps a rectangle of (x, y) offsets between two frames held in a 1-cycle BRAM,
// accumulating the XOR popcount per offset and tracking the minimum-sum offset.
module correlator_sweep
   import correlator_sweep_pkg::*;
#(
   parameter  int LINE_W    = DEF_LINE_W,
   parameter  int WIN_W     = DEF_WIN_W,
   parameter  int WIN_H     = DEF_WIN_H,
   parameter  int Y_RANGE   = DEF_Y_RANGE,
   parameter  int ADDR_W    = DEF_ADDR_W,
   localparam int OFF_RANGE = LINE_W - WIN_W,
   localparam int XW        = $clog2(OFF_RANGE + 1),
   localparam int YW        = $clog2(Y_RANGE + 1),
   localparam int SUM_W     = $clog2(WIN_W * WIN_H + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              go,
   input  logic              abort,
   input  logic [XW-1:0]     x_min,
   input  logic [XW-1:0]     x_max,
   input  logic [YW-1:0]     y_min,
   input  logic [YW-1:0]     y_max,
   input  logic [ADDR_W-1:0] curr_base,
   input  logic [ADDR_W-1:0] prev_base,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   input  logic [LINE_W-1:0] bram_data,
   output logic              res_valid,
   output logic [SUM_W-1:0]  res_sum,
   output logic [XW-1:0]     res_x,
   output logic [YW-1:0]     res_y,
   output logic [SUM_W-1:0]  best_sum,
   output logic [XW-1:0]     best_x,
   output logic [YW-1:0]     best_y,
   output logic              done,
   output logic              err
);

   localparam int Y_CENTER = Y_RANGE / 2;
   localparam int LW       = $clog2(WIN_H + 1);
   localparam int PW       = $clog2(WIN_W + 1);

   corr_state_e       r_state;
   corr_state_e       w_next;
   logic [XW-1:0]     r_x_min;
   logic [XW-1:0]     r_x_max;
   logic [YW-1:0]     r_y_max;
   logic [ADDR_W-1:0] r_curr_base;
   logic [ADDR_W-1:0] r_prev_base;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [LW-1:0]     r_line;
   logic [SUM_W-1:0]  r_acc;
   logic [SUM_W-1:0]  r_best_sum;
   logic [XW-1:0]     r_best_x;
   logic [YW-1:0]     r_best_y;
   logic              r_err;
   logic [WIN_W-1:0]  r_prev_win;
   logic [WIN_W-1:0]  r_curr_win;
   logic [WIN_W-1:0]  w_curr_sel;
   logic [PW-1:0]     w_pop;
   logic              w_illegal;
   logic              w_last_line;
   logic              w_last_x;
   logic              w_last_off;

   // Shifting right by (OFF_RANGE - x) is the same slice as [LINE_W-1-x -: WIN_W].
   assign w_curr_sel  = WIN_W'(bram_data >> (XW'(OFF_RANGE) - r_x));
   assign w_illegal   = (x_min > x_max) || (y_min > y_max) ||
                        (x_max > XW'(OFF_RANGE)) || (y_max > YW'(Y_RANGE));
   assign w_last_line = (r_line == LW'(WIN_H - 1));
   assign w_last_x    = (r_x == r_x_max);
   assign w_last_off  = w_last_x && (r_y == r_y_max);

   popcount_reg #(.N(WIN_W)) u_pop (
      .clk     (clk),
      .resetn  (resetn),
      .i_data  (r_prev_win ^ r_curr_win),
      .o_count (w_pop)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode plus BRAM and status strobes; abort overrides everything.
   always_comb begin
      w_next    = r_state;
      bram_en   = 1'b0;
      bram_addr = '0;
      res_valid = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (go) begin
               w_next = w_illegal ? S_DONE : S_RD_P;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RD_P: begin
            bram_en   = 1'b1;
            bram_addr = r_prev_base + ADDR_W'(Y_CENTER) + ADDR_W'(r_line);
            w_next    = S_RD_C;
         end
         S_RD_C: begin
            bram_en   = 1'b1;
            bram_addr = r_curr_base + ADDR_W'(r_y) + ADDR_W'(r_line);
            w_next    = S_LD_C;
         end
         S_LD_C:  w_next = S_POP;
         S_POP:   w_next = S_ACC;
         S_ACC:   w_next = w_last_line ? S_CMP : S_RD_P;
         S_CMP: begin
            res_valid = 1'b1;
            w_next    = w_last_off ? S_DONE : S_RD_P;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = go ? S_DONE : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (abort) begin
         w_next    = S_IDLE;
         res_valid = 1'b0;
         done      = 1'b0;
      end
   end

   // Datapath: config latch, window capture, accumulation and best tracking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x_min     <= '0;
         r_x_max     <= '0;
         r_y_max     <= '0;
         r_curr_base <= '0;
         r_prev_base <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_line      <= '0;
         r_acc       <= '0;
         r_best_sum  <= '0;
         r_best_x    <= '0;
         r_best_y    <= '0;
         r_err       <= 1'b0;
         r_prev_win  <= '0;
         r_curr_win  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (go && !abort) begin
                  r_x_min     <= x_min;
                  r_x_max     <= x_max;
                  r_y_max     <= y_max;
                  r_curr_base <= curr_base;
                  r_prev_base <= prev_base;
                  r_x         <= x_min;
                  r_y         <= y_min;
                  r_line      <= '0;
                  r_acc       <= '0;
                  r_best_sum  <= '1;
                  r_best_x    <= x_min;
                  r_best_y    <= y_min;
                  r_err       <= w_illegal;
               end
            end
            S_RD_C: r_prev_win <= bram_data[LINE_W-1-OFF_RANGE/2 -: WIN_W];
            S_LD_C: r_curr_win <= w_curr_sel;
            S_ACC: begin
               r_acc  <= r_acc + SUM_W'(w_pop);
               r_line <= w_last_line ? '0 : r_line + LW'(1);
            end
            S_CMP: begin
               if (!abort) begin
                  // Strict compare keeps the earliest offset on ties.
                  if (r_acc < r_best_sum) begin
                     r_best_sum <= r_acc;
                     r_best_x   <= r_x;
                     r_best_y   <= r_y;
                  end
                  r_acc <= '0;
                  if (!w_last_off) begin
                     if (w_last_x) begin
                        r_x <= r_x_min;
                        r_y <= r_y + YW'(1);
                     end else begin
                        r_x <= r_x + XW'(1);
                     end
                  end
               end
            end
            default: r_acc <= r_acc;
         endcase
      end
   end

   assign res_sum  = r_acc;
   assign res_x    = r_x;
   assign res_y    = r_y;
   assign best_sum = r_best_sum;
   assign best_x   = r_best_x;
   assign best_y   = r_best_y;
   assign err      = r_err;

endmodule

// File: tb/tb_correlator_sweep.sv
// Directed bench for correlator_sweep with WIN_H=4, a 1-cycle BRAM model and a
// bit-serial reference model of the window XOR popcount.
module tb_correlator_sweep;

   localparam int WIN_H  = 4;
   localparam int P      = 5 * WIN_H + 1;
   localparam int LINE_W = 128;
   localparam int ADDR_W = 10;
   localparam int XW     = 6;
   localparam int YW     = 6;
   localparam int SUM_W  = 9;

   logic              clk = 1'b0;
   logic              resetn;
   logic              go;
   logic              abort;
   logic [XW-1:0]     x_min, x_max;
   logic [YW-1:0]     y_min, y_max;
   logic [ADDR_W-1:0] curr_base, prev_base;
   logic [ADDR_W-1:0] bram_addr;
   logic              bram_en;
   logic [LINE_W-1:0] bram_q;
   logic              res_valid;
   logic [SUM_W-1:0]  res_sum, best_sum;
   logic [XW-1:0]     res_x, best_x;
   logic [YW-1:0]     res_y, best_y;
   logic              done, err;

   logic [LINE_W-1:0] mem [0:1023];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_en) bram_q <= mem[bram_addr];
   end

   correlator_sweep #(.WIN_H(WIN_H)) dut (
      .clk(clk), .resetn(resetn), .go(go), .abort(abort),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .curr_base(curr_base), .prev_base(prev_base),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_data(bram_q),
      .res_valid(res_valid), .res_sum(res_sum), .res_x(res_x), .res_y(res_y),
      .best_sum(best_sum), .best_x(best_x), .best_y(best_y),
      .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_sum(input int x, input int y, input int cb, input int pb);
      int s;
      logic [LINE_W-1:0] lp, lc;
      logic [ADDR_W-1:0] ap, ac;
      s = 0;
      for (int l = 0; l < WIN_H; l++) begin
         ap = ADDR_W'(pb + 16 + l);
         ac = ADDR_W'(cb + y + l);
         lp = mem[ap];
         lc = mem[ac];
         for (int b = 0; b < 96; b++) begin
            if (lp[16 + b] != lc[32 - x + b]) s++;
         end
      end
      return s;
   endfunction

   task automatic set_cfg(input int xmn, input int xmx, input int ymn, input int ymx,
                          input int cb, input int pb);
      x_min     = XW'(xmn);
      x_max     = XW'(xmx);
      y_min     = YW'(ymn);
      y_max     = YW'(ymx);
      curr_base = ADDR_W'(cb);
      prev_base = ADDR_W'(pb);
   endtask

   // Full legal sweep checked pulse by pulse against the reference model.
   task automatic sweep(input string tag, input int xmn, input int xmx, input int ymn,
                        input int ymx, input int cb, input int pb);
      int t, k, n_off, s, bs, bx, by, ex, ey;
      bit fin;
      n_off = (xmx - xmn + 1) * (ymx - ymn + 1);
      set_cfg(xmn, xmx, ymn, ymx, cb, pb);
      go = 1'b1;
      bs = (1 << SUM_W) - 1;
      bx = xmn; by = ymn; ex = xmn; ey = ymn;
      k = 0; t = 0; fin = 1'b0;
      while (!fin && t < 2000) begin
         @(posedge clk);
         t++;
         @(negedge clk);
         if (res_valid) begin
            k++;
            s = ref_sum(ex, ey, cb, pb);
            check($sformatf("%s_t%0d", tag, k), 64'(t), 64'(k * P));
            check($sformatf("%s_x%0d", tag, k), 64'(res_x), 64'(ex));
            check($sformatf("%s_y%0d", tag, k), 64'(res_y), 64'(ey));
            check($sformatf("%s_sum%0d", tag, k), 64'(res_sum), 64'(s));
            if (s < bs) begin
               bs = s; bx = ex; by = ey;
            end
            if (ex == xmx) begin
               ex = xmn; ey++;
            end else begin
               ex++;
            end
         end
         if (done) fin = 1'b1;
      end
      check({tag, "_finished"}, 64'(fin), 64'(1));
      check({tag, "_done_t"}, 64'(t), 64'(1 + n_off * P));
      check({tag, "_pulses"}, 64'(k), 64'(n_off));
      check({tag, "_best_sum"}, 64'(best_sum), 64'(bs));
      check({tag, "_best_x"}, 64'(best_x), 64'(bx));
      check({tag, "_best_y"}, 64'(best_y), 64'(by));
      check({tag, "_err"}, 64'(err), 64'(0));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_done"}, 64'(done), 64'(1));
      check({tag, "_hold_noread"}, 64'(bram_en), 64'(0));
      go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle"}, 64'(done), 64'(0));
   endtask

   initial begin
      int s0, s1;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 200; i < 264; i++) mem[i] = '1;
      for (int i = 300; i < 364; i++) mem[i] = {8{16'h00FF}};
      bram_q = '0;
      resetn = 1'b0; go = 1'b0; abort = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_best_sum", 64'(best_sum), 64'(0));
      check("rst_bram_en", 64'(bram_en), 64'(0));
      check("rst_res_valid", 64'(res_valid), 64'(0));
      resetn = 1'b1;
      @(negedge clk);

      sweep("ident", 0, 32, 16, 16, 0, 0);
      check("ident_hand_x", 64'(best_x), 64'(16));
      check("ident_hand_y", 64'(best_y), 64'(16));
      check("ident_hand_sum", 64'(best_sum), 64'(0));

      sweep("inv", 2, 3, 5, 6, 200, 100);
      check("inv_hand_sum", 64'(best_sum), 64'(384));
      check("inv_hand_x", 64'(best_x), 64'(2));
      check("inv_hand_y", 64'(best_y), 64'(5));

      sweep("single", 0, 0, 0, 0, 0, 300);

      set_cfg(5, 4, 0, 0, 0, 0);
      go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ill_done", 64'(done), 64'(1));
      check("ill_err", 64'(err), 64'(1));
      check("ill_best_sum", 64'(best_sum), 64'(511));
      check("ill_bram_en", 64'(bram_en), 64'(0));
      go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ill_idle", 64'(done), 64'(0));
      check("ill_idle_bram_en", 64'(bram_en), 64'(0));
      set_cfg(0, 0, 0, 33, 0, 0);
      go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ill_y_err", 64'(err), 64'(1));
      check("ill_y_done", 64'(done), 64'(1));
      go = 1'b0;
      @(posedge clk);
      @(negedge clk);

      set_cfg(0, 32, 16, 16, 0, 0);
      go = 1'b1;
      repeat (52) @(negedge clk);
      abort = 1'b1;
      go = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      s0 = ref_sum(0, 16, 0, 0);
      s1 = ref_sum(1, 16, 0, 0);
      check("abort_done", 64'(done), 64'(0));
      check("abort_bram_en", 64'(bram_en), 64'(0));
      check("abort_best_sum", 64'(best_sum), 64'((s1 < s0) ? s1 : s0));
      check("abort_best_x", 64'(best_x), 64'((s1 < s0) ? 1 : 0));
      @(negedge clk);
      check("abort_stays_idle", 64'(bram_en | res_valid | done), 64'(0));
      sweep("rerun", 0, 32, 16, 16, 0, 0);

      set_cfg(2, 3, 5, 6, 200, 100);
      go = 1'b1;
      repeat (30) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("arst_bram_addr", 64'(bram_addr), 64'(0));
      check("arst_bram_en", 64'(bram_en), 64'(0));
      check("arst_best_sum", 64'(best_sum), 64'(0));
      check("arst_res_x", 64'(res_x), 64'(0));
      check("arst_res_sum", 64'(res_sum), 64'(0));
      check("arst_done", 64'(done | err | res_valid), 64'(0));
      @(negedge clk);
      go = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      sweep("post_rst", 2, 3, 5, 6, 200, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
